// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl -- control block for a pushbutton stopwatch.
//
// The three raw buttons are each synchronized and debounced. Their debounced
// rising edges become one-cycle press events. The press events drive an
// IDLE / RUNNING / PAUSED state machine and a tick prescaler. The outputs
// drive an external counter chain: tick is the count strobe, run is the
// enable, and clear is the reset.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   When defined, a lap press while RUNNING toggles lap_hold, which freezes
//   the display. When undefined, btn_lap is ignored, lap_hold is tied to 0,
//   and no lap logic is built.
//
// Parameters
//   CLK_HZ          system clock frequency in Hz
//   TICK_HZ         tick rate in Hz; DIV = CLK_HZ/TICK_HZ must be >= 2
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a new level
//
// Ports
//   clk            system clock; all logic runs on its rising edge
//   reset          synchronous, active-high reset
//   btn_startstop  raw start/stop pushbutton, active-high
//   btn_clear      raw clear pushbutton, active-high
//   btn_lap        raw lap pushbutton, active-high (lap build only)
//   tick           one-cycle count strobe at TICK_HZ while running
//   run            high while RUNNING
//   clear          one-cycle counter-chain reset pulse
//   lap_hold       high while the display is frozen for a lap
// ---------------------------------------------------------------------------

// One button lane. A 2-flop synchronizer feeds a debouncer. The debouncer
// produces a one-cycle press strobe on each debounced 0->1 transition.
module sw_debounce #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    // The counter only has to reach CYCLES-1.
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            // The count runs only while the synchronized input disagrees
            // with the accepted level. Any agreeing cycle restarts the count.
            // The level flips at the end of the CYCLES-th disagreeing cycle.
            if (sync2 != level) begin
                if (cnt == CW'(CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;
endmodule

module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_startstop,
    input  logic btn_clear,
    input  logic btn_lap,
    output logic tick,
    output logic run,
    output logic clear,
    output logic lap_hold
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- buttons
    // Lane 0 is start/stop, lane 1 is clear, and lane 2 (lap build only) is lap.
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_ev;

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {btn_lap, btn_clear, btn_startstop};
`else
    assign btn_raw = {btn_clear, btn_startstop};
    // The lap input has no function in this build.
    logic lap_unused;
    assign lap_unused = btn_lap;
`endif

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        sw_debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[g]),
            .press (btn_ev[g])
        );
    end

    logic ss_ev;
    logic clr_ev;
    assign ss_ev  = btn_ev[0];
    assign clr_ev = btn_ev[1];

    // ---------------------------------------------------------------- state
    state_t        state;
    state_t        state_n;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic          tick_n;
    logic          run_n;
    // Set by reset. It produces the one clear pulse after reset releases.
    logic          rst_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            presc <= '0;
            rst_q <= 1'b1;
            tick  <= 1'b0;
            run   <= 1'b0;
            clear <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            rst_q <= 1'b0;
            tick  <= tick_n;
            run   <= run_n;
            clear <= clr_ev | rst_q;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;

        // Clear wins over start/stop in the same cycle.
        if (clr_ev) begin
            state_n = IDLE;
        end else if (ss_ev) begin
            case (state)
                IDLE:    state_n = RUNNING;
                RUNNING: state_n = PAUSED;
                PAUSED:  state_n = RUNNING;
                default: state_n = IDLE;
            endcase
        end

        // The prescaler advances in every cycle spent in RUNNING, including
        // the cycle of a pause press. It holds in PAUSED so that a partial
        // period carries over the pause.
        if (clr_ev) begin
            presc_n = '0;
        end else if (state == RUNNING) begin
            presc_n = (presc == PW'(DIV - 1)) ? '0 : presc + PW'(1);
        end

        // These outputs are registered from next-state values. That way they
        // line up with the state and prescaler held in the same cycle.
        // A clear forces state_n to IDLE, so tick can never coincide with it.
        run_n  = (state_n == RUNNING);
        tick_n = (state_n == RUNNING) && (presc_n == PW'(DIV - 1));
    end

    // ---------------------------------------------------------------- lap
`ifdef STOPWATCH_LAP_EN
    logic lap_ev;
    logic lap_n;
    assign lap_ev = btn_ev[2];

    always_comb begin
        lap_n = lap_hold;
        if (clr_ev) begin
            lap_n = 1'b0;
        end else if (lap_ev && (state == RUNNING)) begin
            lap_n = ~lap_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_hold <= 1'b0;
        end else begin
            lap_hold <= lap_n;
        end
    end
`else
    assign lap_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic btn_startstop;
    logic btn_clear;
    logic btn_lap;
    logic tick;
    logic run;
    logic clear;
    logic lap_hold;

`ifdef STOPWATCH_LAP_EN
    localparam bit L = 1'b1;
`else
    localparam bit L = 1'b0;
`endif

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ          (10),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_startstop (btn_startstop),
        .btn_clear     (btn_clear),
        .btn_lap       (btn_lap),
        .tick          (tick),
        .run           (run),
        .clear         (clear),
        .lap_hold      (lap_hold)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Free-running observers, sampled on the falling edge.
    int tick_cnt = 0;
    int clr_cnt  = 0;
    int overlap  = 0;
    always @(negedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
        if (clear) clr_cnt <= clr_cnt + 1;
        if (tick && clear) overlap <= overlap + 1;
    end

    typedef struct {
        bit ss;
        bit clr;
        bit lap;
        bit exp_run;
        bit exp_lap;
        int exp_clr;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle; sample and drive just after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Hold the buttons for 10 cycles, release them, then let the
    // debouncers settle.
    task automatic press(input bit ss, input bit clr, input bit lap);
        btn_startstop = ss;
        btn_clear     = clr;
        btn_lap       = lap;
        repeat (10) step();
        btn_startstop = 1'b0;
        btn_clear     = 1'b0;
        btn_lap       = 1'b0;
        repeat (12) step();
    endtask

    // Press start/stop. Count the cycles with run high, up to and including
    // the first tick. The result is -1 if no tick arrives within the bound.
    task automatic measure_first(output int n);
        bit found = 1'b0;
        n = 0;
        btn_startstop = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (i == 9) btn_startstop = 1'b0;
            if (run) n++;
            if (tick) found = 1'b1;
        end
        btn_startstop = 1'b0;
        if (!found) n = -1;
    endtask

    // Count the cycles from the current tick sample to the next tick.
    task automatic measure_interval(output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            n++;
            if (tick) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t0;
        int c0;
        int runlow;

        //            ss    clr   lap   run   lap   clears
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, L,    0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, L,    0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, L,    0};  // pause keeps lap
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, L,    0};  // lap ignored paused
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, L,    0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};  // clear drops lap
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};  // clear in idle
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};  // lap ignored idle
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};  // clear priority
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};

        btn_startstop = 1'b0;
        btn_clear     = 1'b0;
        btn_lap       = 1'b0;

        // ---- reset: 3 cycles high, then one clear pulse
        reset = 1'b1;
        repeat (3) @(posedge clk);
        step();
        check("rst_run", run, 0);
        check("rst_tick", tick, 0);
        check("rst_lap", lap_hold, 0);
        reset = 1'b0;
        step();
        check("rst_clear_hi", clear, 1);
        step();
        check("rst_clear_lo", clear, 0);
        repeat (3) step();

        // ---- start from IDLE: first tick in the 10th run cycle, then every 10
        measure_first(n);
        check("start_first_tick", n, 10);
        measure_interval(n);
        check("tick_period_1", n, 10);
        measure_interval(n);
        check("tick_period_2", n, 10);

        // ---- pause when the prescaler reads 6. The press event lands 6
        //      cycles after the drive, and the prescaler is 0 one cycle
        //      after a tick.
        step();
        btn_startstop = 1'b1;
        t0 = tick_cnt;
        repeat (10) step();
        btn_startstop = 1'b0;
        repeat (50) step();
        check("pause_run", run, 0);
        check("pause_no_tick", tick_cnt - t0, 0);
        measure_first(n);
        check("resume_first_tick", n, 3);

        // ---- bounce while running: no event, counting undisturbed
        t0 = tick_cnt;
        c0 = clr_cnt;
        runlow = 0;
        for (int i = 0; i < 12; i++) begin
            btn_startstop = ((i / 2) % 2) == 0;
            step();
            if (!run) runlow++;
        end
        btn_startstop = 1'b0;
        repeat (20) begin
            step();
            if (!run) runlow++;
        end
        check("bounce_run_low_cycles", runlow, 0);
        check("bounce_ticks", tick_cnt - t0, 3);
        check("bounce_clears", clr_cnt - c0, 0);

        // ---- clear and start/stop together mid-period: clear wins, prescaler zeroed
        repeat (4) step();
        c0 = clr_cnt;
        press(1'b1, 1'b1, 1'b0);
        check("prio_run", run, 0);
        check("prio_clears", clr_cnt - c0, 1);
        measure_first(n);
        check("prio_restart_first_tick", n, 10);

        // ---- reset while running: no further ticks
        repeat (5) step();
        reset = 1'b1;
        step();
        t0 = tick_cnt;
        c0 = clr_cnt;
        step();
        reset = 1'b0;
        repeat (30) step();
        check("midrst_ticks", tick_cnt - t0, 0);
        check("midrst_run", run, 0);
        check("midrst_clears", clr_cnt - c0, 1);

        // ---- table-driven button sequences
        for (int v = 0; v < 14; v++) begin
            c0 = clr_cnt;
            press(vecs[v].ss, vecs[v].clr, vecs[v].lap);
            check($sformatf("vec%0d_run", v), run, vecs[v].exp_run);
            check($sformatf("vec%0d_lap", v), lap_hold, vecs[v].exp_lap);
            check($sformatf("vec%0d_clears", v), clr_cnt - c0, vecs[v].exp_clr);
        end

`ifdef STOPWATCH_LAP_EN
        // ---- the lap hold leaves counting alone
        measure_first(n);
        check("lap_start_first_tick", n, 10);
        press(1'b0, 1'b0, 1'b1);
        check("lap_on", lap_hold, 1);
        t0 = tick_cnt;
        repeat (25) step();
        check("lap_ticks_continue", (tick_cnt - t0) >= 2, 1);
        check("lap_run", run, 1);
        press(1'b0, 1'b0, 1'b1);
        check("lap_off", lap_hold, 0);
        press(1'b0, 1'b1, 1'b0);
`endif

        check("tick_clear_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, count-tick rate in Hz; DIV = CLK_HZ/TICK_HZ, with DIV >= 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, required stable cycles (20 ms at 50 MHz), >= 1.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port btn_startstop  input  1  raw asynchronous pushbutton, active-high.
REQ-007 SHALL have port btn_clear  input  1  raw asynchronous pushbutton, active-high.
REQ-008 SHALL have port btn_lap  input  1  raw asynchronous pushbutton, active-high (used only per REQ-024).
REQ-009 SHALL have port tick  output  1  one-cycle pulse at TICK_HZ while running; drives the counter chain's count input.
REQ-010 SHALL have port run  output  1  high while in state RUNNING; drives the counter chain's enable.
REQ-011 SHALL have port clear  output  1  one-cycle pulse; drives the counter chain's reset.
REQ-012 SHALL have port lap_hold  output  1  high while the display is frozen for a lap.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a debouncer.
- Debounced level updates only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch break restarts the count.
REQ-014 SHALL generate a one-cycle press event on each 0->1 transition of a debounced level; holding a button produces exactly one event.
REQ-015 SHALL implement FSM states IDLE, RUNNING, PAUSED.
- Start/stop event: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING.
- Clear event: any state -> IDLE.
REQ-016 SHALL, on a clear event, assert clear for exactly one cycle at the same edge the FSM enters IDLE, and zero the prescaler.
REQ-017 SHALL give priority to clear when clear and start/stop events occur in the same cycle; the start/stop event is discarded.
REQ-018 SHALL run prescaler 0..DIV-1 only in RUNNING and wrap to 0 after DIV-1.
- tick is high in the cycle the prescaler equals DIV-1 and the state is RUNNING.
REQ-019 SHALL hold the prescaler value in PAUSED, so partial periods are preserved across pause/resume.
REQ-020 SHALL produce the first tick exactly DIV cycles after entering RUNNING from IDLE.
REQ-021 SHALL register all outputs; state-driven outputs change at the clock edge after the press event cycle.
REQ-022 SHALL keep clear and tick mutually exclusive in any cycle.

Reset
REQ-023 SHALL, on reset high at a clock edge, set:
- state = IDLE, prescaler = 0;
- debounced levels and synchronizers = 0, debounce counters = 0;
- tick = 0, run = 0, clear = 1 for the cycle after reset deasserts, lap_hold = 0.
Reset mid-RUNNING aborts counting with no further tick.

Configuration
REQ-024 SHALL compile the lap feature under macro STOPWATCH_LAP_EN.
- Defined: a btn_lap event in RUNNING toggles lap_hold; btn_lap events in IDLE or PAUSED are ignored; a clear event or reset forces lap_hold = 0; counting and tick are unaffected by lap_hold.
- Undefined: btn_lap is ignored, lap_hold is tied to 0, and no lap logic is synthesized.

Verification (CLK_HZ=10, TICK_HZ=1 so DIV=10; DEBOUNCE_CYCLES=4)
REQ-025 SHALL cover reset: reset high 3 cycles, then low -> run=0, tick=0, lap_hold=0; clear=1 for one cycle, then 0.
REQ-026 SHALL cover start: btn_startstop held 10 cycles -> one press event, run=1; tick pulses exactly every 10 cycles, first pulse 10 cycles after run rises.
REQ-027 SHALL cover bounce: btn_startstop toggles every 2 cycles for 12 cycles, then stays low -> no press event, state unchanged.
REQ-028 SHALL cover pause/resume: pause when prescaler=6, wait 50 cycles, resume -> no tick while paused; next tick 3 cycles after run rises.
REQ-029 SHALL cover clear priority: start/stop and clear debounced-rise in the same cycle while RUNNING -> state IDLE, one clear pulse, run=0, prescaler=0.
REQ-030 SHALL cover lap (STOPWATCH_LAP_EN defined): btn_lap press in RUNNING -> lap_hold=1, ticks continue; second press -> lap_hold=0; press in PAUSED -> no change.
